game_status: RTL
================

Name: game_status

Overview:
- Game-state controller sitting directly downstream of the matcher in the lianliankan pipeline.
- Consumes the matcher's one-cycle match-success/match-fail pulses and the 36-bit hidden_bus; owns the round countdown and the score.
- Produces play/freeze, win and lose indications for the display and the input path.
- Start/restart comes from the debounced select key (s_d).

Parameters:
- CLK_HZ, 100000000, clock cycles per one-second tick of the countdown.
- TIME_LIMIT, 120, starting and maximum seconds per round (1..255).
- TIME_BONUS, 3, seconds added per successful match.
- MATCH_BONUS, 10, score points added per successful match.
- FAIL_PENALTY, 2, score points removed per failed match.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse, debounced select key.
- ms  in  1  match success pulse from matcher.
- mf  in  1  match fail pulse from matcher.
- hidden_bus  in  36  1 = card removed.
- state  out  2  00 IDLE, 01 PLAY, 10 WIN, 11 LOSE.
- time_left  out  8  seconds remaining.
- score  out  10  current score, 0..999.
- tick_1hz  out  1  one-cycle pulse per elapsed second in PLAY.
- freeze  out  1  1 = card/cursor input must be ignored.
- game_over  out  1  1 in WIN or LOSE.
- win  out  1  1 in WIN only.

Behaviour:
- Reset (rst=0, asynchronous), all outputs registered:
  - state=IDLE, score=0, time_left=TIME_LIMIT, prescaler=0.
  - tick_1hz=0, freeze=1, game_over=0, win=0.
- Prescaler: $clog2(CLK_HZ)-bit counter.
  - Counts only in PLAY. At CLK_HZ-1 it wraps to 0 and tick_1hz is high the next cycle.
  - Held at 0 outside PLAY.
- IDLE -> PLAY on start:
  - Same edge loads score=0, time_left=TIME_LIMIT, prescaler=0.
  - freeze drops the following cycle.
- PLAY, evaluated each cycle in this priority:
  1. hidden_bus == all ones -> WIN (overrides timeout in the same cycle).
  2. tick with time_left==1 and no ms -> time_left=0, LOSE.
  3. Otherwise update time and score as below.
- Time arithmetic:
  - Computed 9 bits wide: next = time_left - tick + (ms ? TIME_BONUS : 0).
  - Saturates at TIME_LIMIT. Never underflows.
- Score arithmetic:
  - ms: score + MATCH_BONUS, saturating at 999.
  - mf: score - FAIL_PENALTY, floored at 0.
  - ms and mf in the same cycle: ms applies, mf is ignored.
- start in PLAY is ignored (no restart mid-round).
- WIN / LOSE:
  - time_left and score frozen; freeze=1, game_over=1, win=(state==WIN).
  - start -> IDLE, with score and time_left keeping their final values until the next IDLE->PLAY load.
- ms, mf and tick have no effect outside PLAY.
- hidden_bus already all ones when start arrives: enter PLAY, then WIN on the next cycle.
- Reset asserted mid-round: immediate return to IDLE with reset values; no pending tick survives.
- All state changes on the rising clk edge; output latency is 1 cycle from the qualifying input.

Test Plan:
- Use CLK_HZ=4, TIME_LIMIT=5 for all scenarios.
- Round start: rst low then high, start pulse -> state=01, time_left=5, score=0, freeze=0; tick_1hz every 4 cycles; time_left 5,4,3,2,1 then state=11, game_over=1, win=0, time_left=0.
- Scoring: in PLAY, ms x3, mf x1 -> score=28. Fresh round, mf x2 -> score=0 (floor). Preload via 100 ms pulses -> score=999 (saturate).
- Time bonus: ms at time_left=4 -> 5 (saturates at TIME_LIMIT). ms coincident with tick at time_left=1 -> time_left=3, state stays PLAY.
- Win priority: drive hidden_bus=36'hFFFFFFFFF in the same cycle as the final tick at time_left=1 -> state=10, win=1, time_left=1.
- Restart and ignore: start pulse during PLAY -> no change. In LOSE, ms/mf pulses -> score unchanged. start from LOSE -> IDLE; second start -> PLAY with score=0, time_left=5.
- Async reset mid-round: rst low for 1 ns between clk edges at time_left=3 -> outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/game_status.sv
// Lianliankan game-state controller: round countdown, score keeping and
// play/win/lose sequencing downstream of the pair matcher.
module game_status #(
  parameter int unsigned CLK_HZ       = 100000000,
  parameter int unsigned TIME_LIMIT   = 120,
  parameter int unsigned TIME_BONUS   = 3,
  parameter int unsigned MATCH_BONUS  = 10,
  parameter int unsigned FAIL_PENALTY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ms,
  input  logic        mf,
  input  logic [35:0] hidden_bus,
  output logic [1:0]  state,
  output logic [7:0]  time_left,
  output logic [9:0]  score,
  output logic        tick_1hz,
  output logic        freeze,
  output logic        game_over,
  output logic        win
);

  localparam int unsigned PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned TW        = 9;
  localparam int unsigned SW        = 11;
  localparam int unsigned SCORE_MAX = 999;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_WIN  = 2'b10,
    S_LOSE = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      time_q, time_d;
  logic [9:0]      score_q, score_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic            tick_q, tick_d;
  logic            freeze_q, freeze_d;
  logic            over_q, over_d;
  logic            win_q, win_d;

  logic            wrap;
  logic            all_hidden;
  logic [TW-1:0]   time_sum;
  logic [7:0]      time_sat;
  logic [SW-1:0]   score_sum;
  logic [9:0]      score_up;
  logic [9:0]      score_dn;

  // Second boundary and saturating time/score arithmetic for the PLAY update
  always_comb begin
    wrap       = (state_q == S_PLAY) && (pre_q == PW'(CLK_HZ - 1));
    all_hidden = &hidden_bus;
    time_sum   = TW'(time_q) - TW'(wrap) + (ms ? TW'(TIME_BONUS) : TW'(0));
    time_sat   = (time_sum > TW'(TIME_LIMIT)) ? 8'(TIME_LIMIT) : time_sum[7:0];
    score_sum  = SW'(score_q) + SW'(MATCH_BONUS);
    score_up   = (score_sum > SW'(SCORE_MAX)) ? 10'(SCORE_MAX) : score_sum[9:0];
    score_dn   = (score_q < 10'(FAIL_PENALTY)) ? 10'd0 : score_q - 10'(FAIL_PENALTY);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    score_d = score_q;
    pre_d   = '0;
    tick_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PLAY;
          time_d  = 8'(TIME_LIMIT);
          score_d = 10'd0;
        end
      end
      S_PLAY: begin
        pre_d  = wrap ? '0 : pre_q + PW'(1);
        tick_d = wrap;
        if (all_hidden) begin
          state_d = S_WIN;
        end else if (wrap && (time_q == 8'd1) && !ms) begin
          time_d  = 8'd0;
          state_d = S_LOSE;
        end else begin
          time_d = time_sat;
          if (ms) begin
            score_d = score_up;
          end else if (mf) begin
            score_d = score_dn;
          end
        end
      end
      S_WIN, S_LOSE: begin
        if (start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != S_PLAY) begin
      pre_d = '0;
    end

    freeze_d = (state_d != S_PLAY);
    over_d   = (state_d == S_WIN) || (state_d == S_LOSE);
    win_d    = (state_d == S_WIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      time_q   <= 8'(TIME_LIMIT);
      score_q  <= 10'd0;
      pre_q    <= '0;
      tick_q   <= 1'b0;
      freeze_q <= 1'b1;
      over_q   <= 1'b0;
      win_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      score_q  <= score_d;
      pre_q    <= pre_d;
      tick_q   <= tick_d;
      freeze_q <= freeze_d;
      over_q   <= over_d;
      win_q    <= win_d;
    end
  end

  assign state     = state_q;
  assign time_left = time_q;
  assign score     = score_q;
  assign tick_1hz  = tick_q;
  assign freeze    = freeze_q;
  assign game_over = over_q;
  assign win       = win_q;

endmodule
